// File: rtl/pad_pkg.sv
// Shared definitions for the SNES pad reader and the player FSM that
// consumes input_data: button positions, serial bit order, state encoding.
package pad_pkg;

  // Bit positions in the 10-bit input_data bus (active-high buttons)
  localparam int BTN_B      = 9;
  localparam int BTN_RIGHT  = 8;
  localparam int BTN_LEFT   = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_UP     = 5;
  localparam int BTN_A      = 4;
  localparam int BTN_Y      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_START  = 1;
  localparam int BTN_SELECT = 0;

  // Order in which the pad shifts its buttons out (bit 0 first)
  localparam int SER_B      = 0;
  localparam int SER_Y      = 1;
  localparam int SER_SELECT = 2;
  localparam int SER_START  = 3;
  localparam int SER_UP     = 4;
  localparam int SER_DOWN   = 5;
  localparam int SER_LEFT   = 6;
  localparam int SER_RIGHT  = 7;
  localparam int SER_A      = 8;
  localparam int SER_X      = 9;
  localparam int SER_L      = 10;
  localparam int SER_R      = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_CLK_HI = 3'd4,
    ST_COMMIT = 3'd5
  } pad_state_t;

  // Reorder the first ten serial bits (1 = pressed) onto the input_data
  // layout; an opposing direction pair pressed together cancels out.
  function automatic logic [9:0] map_buttons(input logic [9:0] raw);
    logic [9:0] btn;
    btn             = 10'd0;
    btn[BTN_B]      = raw[SER_B];
    btn[BTN_A]      = raw[SER_A];
    btn[BTN_Y]      = raw[SER_Y];
    btn[BTN_X]      = raw[SER_X];
    btn[BTN_START]  = raw[SER_START];
    btn[BTN_SELECT] = raw[SER_SELECT];
    btn[BTN_UP]     = raw[SER_UP]    & ~raw[SER_DOWN];
    btn[BTN_DOWN]   = raw[SER_DOWN]  & ~raw[SER_UP];
    btn[BTN_LEFT]   = raw[SER_LEFT]  & ~raw[SER_RIGHT];
    btn[BTN_RIGHT]  = raw[SER_RIGHT] & ~raw[SER_LEFT];
    return btn;
  endfunction

endpackage

// File: rtl/pad_phase_timer.sv
// Loadable down-counter timing the latch, settle and half-period phases.
// tc is registered and is high on the last cycle of a loaded phase.
module pad_phase_timer #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count_r;

  // Count down from the loaded value, holding at zero; tc tracks count==0
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
      tc      <= 1'b0;
    end else if (load) begin
      count_r <= load_value;
      tc      <= (load_value == '0);
    end else if (count_r != '0) begin
      count_r <= count_r - WIDTH'(1);
      tc      <= (count_r == WIDTH'(1));
    end else begin
      count_r <= count_r;
      tc      <= 1'b1;
    end
  end

endmodule

// File: rtl/snes_pad_reader.sv
// Scans a SNES-style serial pad once per frame and presents the sanitised
// buttons as a level vector that only changes on the commit cycle.
module snes_pad_reader #(
  parameter int unsigned HALF_CYCLES = 75,
  parameter int unsigned NUM_BITS    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [9:0] input_data,
  output logic       data_valid,
  output logic       pad_present
);
  import pad_pkg::*;

  localparam int unsigned   TW         = $clog2(4 * HALF_CYCLES + 1);
  localparam logic [TW-1:0] LATCH_LOAD = TW'(4 * HALF_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT   = 4'(NUM_BITS - 1);

  pad_state_t          state_r;
  logic [3:0]          bit_cnt_r;
  logic [NUM_BITS-1:0] shift_r;
  logic [1:0]          sync_r;
  logic                load_s;
  logic [TW-1:0]       load_value_s;
  logic                tc_s;
  logic [NUM_BITS-1:0] raw_s;
  logic                all_pressed_s;

  assign raw_s         = ~shift_r;
  assign all_pressed_s = &raw_s;

  pad_phase_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_value (load_value_s),
    .tc         (tc_s)
  );

  // Two-flop synchroniser on the asynchronous pad data line (idles high)
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], pad_data};
    end
  end

  // Reload the phase timer on scan start and at every timed phase boundary
  always_comb begin
    load_s       = 1'b0;
    load_value_s = HALF_LOAD;
    case (state_r)
      ST_IDLE: begin
        load_s       = frame_end;
        load_value_s = LATCH_LOAD;
      end
      ST_LATCH, ST_SETTLE, ST_CLK_LO, ST_CLK_HI: begin
        load_s       = tc_s;
        load_value_s = HALF_LOAD;
      end
      default: begin
        load_s       = 1'b0;
        load_value_s = HALF_LOAD;
      end
    endcase
  end

  // Scan sequencer: latch, settle, clock pulses, then a one-cycle commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      pad_latch   <= 1'b0;
      pad_clk     <= 1'b1;
      input_data  <= 10'd0;
      data_valid  <= 1'b0;
      pad_present <= 1'b0;
      bit_cnt_r   <= 4'd0;
      shift_r     <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          pad_latch <= 1'b0;
          pad_clk   <= 1'b1;
          if (frame_end) begin
            state_r   <= ST_LATCH;
            pad_latch <= 1'b1;
            bit_cnt_r <= 4'd0;
          end
        end
        ST_LATCH: begin
          if (tc_s) begin
            state_r   <= ST_SETTLE;
            pad_latch <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (tc_s) begin
            shift_r   <= {sync_r[1], shift_r[NUM_BITS-1:1]};
            bit_cnt_r <= 4'd1;
            state_r   <= ST_CLK_LO;
            pad_clk   <= 1'b0;
          end
        end
        ST_CLK_LO: begin
          if (tc_s) begin
            state_r <= ST_CLK_HI;
            pad_clk <= 1'b1;
          end
        end
        ST_CLK_HI: begin
          if (tc_s) begin
            shift_r <= {sync_r[1], shift_r[NUM_BITS-1:1]};
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= ST_COMMIT;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              state_r   <= ST_CLK_LO;
              pad_clk   <= 1'b0;
            end
          end
        end
        ST_COMMIT: begin
          // Every bit reading pressed means the line is stuck low: no pad
          if (all_pressed_s) begin
            input_data  <= 10'd0;
            pad_present <= 1'b0;
          end else begin
            input_data  <= map_buttons(raw_s[9:0]);
            pad_present <= 1'b1;
          end
          data_valid <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: a pad model feeds the serial line, a timing
// and decode model predicts every output each cycle, and directed scans
// pin the model with hand-computed values.
module tb_snes_pad_reader;

  localparam int H         = 4;
  localparam int NB        = 12;
  localparam int COMMIT_D  = 5 * H + 2 * (NB - 1) * H + 1;   // 109

  logic       clk;
  logic       reset;
  logic       frame_end;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [9:0] input_data;
  logic       data_valid;
  logic       pad_present;

  logic [11:0] buttons;   // 1 = pressed, serial order B,Y,Sel,St,U,D,L,R,A,X,L,R
  logic [3:0]  pad_idx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit done   = 1'b0;

  // monitor statistics
  int latch_rises   = 0;
  int latch_hi_cyc  = 0;
  int clk_falls     = 0;
  int valid_cyc     = 0;

  snes_pad_reader #(.HALF_CYCLES(H), .NUM_BITS(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_end   (frame_end),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .input_data  (input_data),
    .data_valid  (data_valid),
    .pad_present (pad_present)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pad model: latch reloads the shift position, each pad_clk rise advances it
  assign pad_data = (pad_idx < 4'd12) ? ~buttons[pad_idx] : 1'b0;

  initial begin
    pad_idx = 4'd0;
    forever begin
      @(posedge pad_latch or posedge pad_clk);
      if (pad_latch === 1'b1) pad_idx = 4'd0;
      else if (pad_idx < 4'd15) pad_idx = pad_idx + 4'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected {pad_present, input_data} for a set of pressed buttons
  function automatic logic [10:0] expect_buttons(input logic [11:0] p);
    int         dest [12] = '{9, 3, 0, 1, 5, 6, 7, 8, 4, 2, -1, -1};
    logic [9:0] o;
    o = 10'd0;
    if (p == 12'hFFF) return 11'd0;
    for (int k = 0; k < 12; k++)
      if (p[k] && dest[k] >= 0) o[dest[k]] = 1'b1;
    if (o[5] && o[6]) begin o[5] = 1'b0; o[6] = 1'b0; end
    if (o[7] && o[8]) begin o[7] = 1'b0; o[8] = 1'b0; end
    return {1'b1, o};
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full scan from IDLE with latency/pulse-shape checks and decoded result
  task automatic scan(input logic [11:0] b, input logic [9:0] exp_d, input logic exp_p, input string nm);
    int n, lr, lh, cf, vc;
    buttons = b;
    wait_neg(3);
    lr = latch_rises; lh = latch_hi_cyc; cf = clk_falls; vc = valid_cyc;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    n = 0;
    while (!data_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"},    32'(n), 32'(COMMIT_D));
    chk({nm, "_data"},       32'(input_data), 32'(exp_d));
    chk({nm, "_present"},    32'(pad_present), 32'(exp_p));
    chk({nm, "_latch_cnt"},  32'(latch_rises - lr), 32'd1);
    chk({nm, "_latch_len"},  32'(latch_hi_cyc - lh), 32'd16);
    chk({nm, "_clk_pulses"}, 32'(clk_falls - cf), 32'd11);
    chk({nm, "_valid_cnt"},  32'(valid_cyc - vc), 32'd1);
  endtask

  initial begin
    bit          busy;
    int          e0, d;
    logic [11:0] btn_l;
    logic [9:0]  m_data;
    logic        m_present, m_valid, m_latch, m_clk;
    logic        prev_latch, prev_clk;
    logic [10:0] r;

    busy = 1'b0; e0 = 0; btn_l = 12'd0;
    m_data = 10'd0; m_present = 1'b0; m_valid = 1'b0;
    prev_latch = 1'b0; prev_clk = 1'b1;
    reset = 1'b0; frame_end = 1'b0; buttons = 12'd0;

    fork
      // Per-cycle model and comparison
      begin
        while (!done) begin
          @(posedge clk);
          cyc++;
          if (!reset) begin
            busy = 1'b0; m_data = 10'd0; m_present = 1'b0; m_valid = 1'b0;
          end else begin
            m_valid = 1'b0;
            if (busy) begin
              if (cyc - e0 == COMMIT_D) begin
                busy = 1'b0;
                m_valid = 1'b1;
                r = expect_buttons(btn_l);
                m_data = r[9:0];
                m_present = r[10];
              end
            end else if (frame_end) begin
              busy = 1'b1; e0 = cyc; btn_l = buttons;
            end
          end
          d = cyc - e0;
          m_latch = busy && d < 4 * H;
          m_clk = !(busy && d >= 5 * H && d < COMMIT_D - 1 && ((d - 5 * H) / H) % 2 == 0);
          #1;
          chk("cyc_latch",   32'(pad_latch),   32'(m_latch));
          chk("cyc_clk",     32'(pad_clk),     32'(m_clk));
          chk("cyc_valid",   32'(data_valid),  32'(m_valid));
          chk("cyc_data",    32'(input_data),  32'(m_data));
          chk("cyc_present", 32'(pad_present), 32'(m_present));
          if (pad_latch === 1'b1 && prev_latch !== 1'b1) latch_rises++;
          if (pad_latch === 1'b1) latch_hi_cyc++;
          if (pad_clk === 1'b0 && prev_clk === 1'b1) clk_falls++;
          if (data_valid === 1'b1) valid_cyc++;
          prev_latch = pad_latch;
          prev_clk   = pad_clk;
        end
      end
      // Directed stimulus
      begin
        int lr, vc;
        wait_neg(3);
        chk("rst_latch",   32'(pad_latch),   32'd0);
        chk("rst_clk",     32'(pad_clk),     32'd1);
        chk("rst_data",    32'(input_data),  32'd0);
        chk("rst_valid",   32'(data_valid),  32'd0);
        chk("rst_present", 32'(pad_present), 32'd0);
        reset = 1'b1;
        wait_neg(5);

        scan(12'h011, 10'b10_0010_0000, 1'b1, "up_b");
        scan(12'hFFF, 10'b00_0000_0000, 1'b0, "stuck_low");
        scan(12'h1C0, 10'b00_0001_0000, 1'b1, "lr_a");
        scan(12'h038, 10'b00_0000_0010, 1'b1, "ud_start");

        // frame_end during the scan and during COMMIT must be ignored
        buttons = 12'h001;
        wait_neg(3);
        lr = latch_rises; vc = valid_cyc;
        frame_end = 1'b1;
        @(negedge clk);            // d = 0
        frame_end = 1'b0;
        wait_neg(19);
        frame_end = 1'b1;          // sampled at E0+20
        @(negedge clk);
        frame_end = 1'b0;
        wait_neg(88);              // d = 108
        frame_end = 1'b1;          // sampled at the COMMIT edge E0+109
        @(negedge clk);
        frame_end = 1'b0;
        chk("ign_valid_at_109", 32'(data_valid), 32'd1);
        chk("ign_data",         32'(input_data), 32'(10'b10_0000_0000));
        wait_neg(150);
        chk("ign_latch_cnt", 32'(latch_rises - lr), 32'd1);
        chk("ign_valid_cnt", 32'(valid_cyc - vc), 32'd1);

        scan(12'h200, 10'b00_0000_0100, 1'b1, "x_only");

        // Pattern changes between scans: output holds until the next commit
        buttons = 12'h002;
        wait_neg(40);
        chk("hold_data", 32'(input_data), 32'(10'b00_0000_0100));
        scan(12'h002, 10'b00_0000_1000, 1'b1, "y_only");

        // Reset in the middle of a CLK_HI phase aborts the scan
        buttons = 12'h200;
        wait_neg(3);
        vc = valid_cyc;
        frame_end = 1'b1;
        @(negedge clk);            // d = 0
        frame_end = 1'b0;
        wait_neg(49);
        chk("pre_rst_clk_hi", 32'(pad_clk), 32'd1);
        reset = 1'b0;              // sampled at E0+50
        @(negedge clk);
        chk("mid_rst_clk",   32'(pad_clk),     32'd1);
        chk("mid_rst_latch", 32'(pad_latch),   32'd0);
        chk("mid_rst_data",  32'(input_data),  32'd0);
        chk("mid_rst_valid", 32'(data_valid),  32'd0);
        reset = 1'b1;
        wait_neg(150);
        chk("mid_rst_no_valid", 32'(valid_cyc - vc), 32'd0);
        chk("mid_rst_data_held", 32'(input_data), 32'd0);
        scan(12'h011, 10'b10_0010_0000, 1'b1, "after_rst");

        wait_neg(2);
        done = 1'b1;
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
